// File: rtl/dmem_sb_responder_pkg.sv
// Shared defaults and the store-buffer entry layout for the data-memory responder.
package dmem_pkg;
  localparam int unsigned DMEM_ADDR_WIDTH = 10;
  localparam int unsigned DMEM_SB_DEPTH   = 4;

  // Entry layout at the default RAM width; sub-modules redeclare it at their own width.
  typedef struct packed {
    logic [DMEM_ADDR_WIDTH-1:0] idx;
    logic [31:0]                data;
  } sb_entry_t;
endpackage

// File: rtl/dmem_sb_responder_if.sv
// M-stage load/store bus between the CPU pipeline and the data-memory responder.
interface dmem_sb_responder_if #(
  parameter int unsigned SB_DEPTH = 4
);
  logic [31:0]                    addr;
  logic [31:0]                    writedata;
  logic                           memwrite;
  logic                           memread;
  logic [31:0]                    readdata;
  logic [$clog2(SB_DEPTH+1)-1:0]  sb_count;
  logic                           sb_empty;
  logic                           sb_overflow;

  modport master (
    output addr, writedata, memwrite, memread,
    input  readdata, sb_count, sb_empty, sb_overflow
  );

  modport slave (
    input  addr, writedata, memwrite, memread,
    output readdata, sb_count, sb_empty, sb_overflow
  );
endinterface

// File: rtl/dmem_sb_responder_store_buffer.sv
// In-order store FIFO with occupancy count and youngest-match load forwarding.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int unsigned SB_DEPTH   = DMEM_SB_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [ADDR_WIDTH-1:0]         push_idx,
  input  logic [31:0]                   push_data,
  input  logic                          pop,
  input  logic [ADDR_WIDTH-1:0]         lookup_idx,
  output logic [$clog2(SB_DEPTH+1)-1:0] count,
  output logic [ADDR_WIDTH-1:0]         head_idx,
  output logic [31:0]                   head_data,
  output logic                          hit,
  output logic [31:0]                   hit_data
);
  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = $clog2(SB_DEPTH+1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           data;
  } entry_t;

  entry_t        buf_q [SB_DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        buf_q[tail_q] <= '{idx: push_idx, data: push_data};
        tail_q        <= tail_q + PW'(1);
      end
      if (pop) head_q <= head_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // Walk oldest to youngest so the last valid match left standing is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    pos      = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      pos = head_q + PW'(i);
      if ((CW'(i) < count_q) && (buf_q[pos].idx == lookup_idx)) begin
        hit      = 1'b1;
        hit_data = buf_q[pos].data;
      end
    end
  end

  assign count     = count_q;
  assign head_idx  = buf_q[head_q].idx;
  assign head_data = buf_q[head_q].data;
endmodule

// File: rtl/dmem_sb_responder.sv
// Data memory for the M stage: zero-latency loads, stores absorbed by a store buffer
// that drains into a single-port word RAM during load-free cycles.
module dmem_sb_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int unsigned SB_DEPTH   = DMEM_SB_DEPTH
) (
  input logic               clk,
  input logic               rst,
  dmem_sb_responder_if.slave bus
);
  localparam int unsigned CW = $clog2(SB_DEPTH+1);

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] head_idx;
  logic [31:0]           head_data;
  logic [31:0]           fwd_data;
  logic                  fwd_hit;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  overflow_q;
  logic                  unused_addr_bits;

  assign word_idx         = bus.addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

  assign full = (count == CW'(SB_DEPTH));
  assign pop  = !bus.memread && (count != '0);
  // A store into a full buffer is only safe when the same edge drains the head.
  assign push = bus.memwrite && (!full || !bus.memread);

  dmem_store_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SB_DEPTH   (SB_DEPTH)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_idx   (word_idx),
    .push_data  (bus.writedata),
    .pop        (pop),
    .lookup_idx (word_idx),
    .count      (count),
    .head_idx   (head_idx),
    .head_data  (head_data),
    .hit        (fwd_hit),
    .hit_data   (fwd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst && pop) mem[head_idx] <= head_data;
  end

  always_ff @(posedge clk) begin
    if (rst)                                        overflow_q <= 1'b0;
    else if (bus.memwrite && bus.memread && full)   overflow_q <= 1'b1;
  end

  assign bus.readdata    = fwd_hit ? fwd_data : mem[word_idx];
  assign bus.sb_count    = count;
  assign bus.sb_empty    = (count == '0);
  assign bus.sb_overflow = overflow_q;
endmodule

// File: tb/tb_dmem_sb_responder.sv
// Directed bench for dmem_sb_responder: forwarding, draining, overflow and reset behaviour.
module tb_dmem_sb_responder;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  dmem_sb_responder_if #(.SB_DEPTH(4)) bus ();

  dmem_sb_responder #(
    .ADDR_WIDTH (10),
    .SB_DEPTH   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = w;
    bus.memread   = r;
    bus.addr      = a;
    bus.writedata = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Preload RAM word 4 through the store path, then reset.
    drive(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;

    drive(1'b0, 1'b1, 32'h10, 32'h0);
    chk("reset_count", 32'(bus.sb_count), 32'd0);
    chk("reset_empty", 32'(bus.sb_empty), 32'd1);
    chk("reset_ovf", 32'(bus.sb_overflow), 32'd0);
    chk("ram_load", bus.readdata, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 32'h13, 32'h0);
    chk("byte_offset_ignored", bus.readdata, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 32'h1010, 32'h0);
    chk("addr_wrap", bus.readdata, 32'hDEADBEEF);
    tick();

    // Store then forward, then drain on one idle cycle.
    drive(1'b1, 1'b0, 32'h20, 32'h11111111);
    tick();
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    chk("fwd_single", bus.readdata, 32'h11111111);
    chk("count_one", 32'(bus.sb_count), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    chk("drain_empty", 32'(bus.sb_empty), 32'd1);
    chk("drained_ram", bus.readdata, 32'h11111111);
    tick();

    // Two stores to one word with loads asserted: youngest wins.
    drive(1'b1, 1'b1, 32'h40, 32'h0000000A);
    tick();
    drive(1'b1, 1'b1, 32'h40, 32'h0000000B);
    chk("same_cycle_invisible", bus.readdata, 32'h0000000A);
    tick();
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    chk("youngest_wins", bus.readdata, 32'h0000000B);
    chk("count_two", 32'(bus.sb_count), 32'd2);
    chk("no_ovf_two", 32'(bus.sb_overflow), 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    chk("drain_order", bus.readdata, 32'h0000000B);
    chk("drain_two_empty", 32'(bus.sb_empty), 32'd1);
    tick();

    // Alternating store/load: each store drains the previous one.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h5A000000 + 32'(k));
      tick();
      drive(1'b0, 1'b1, 32'h10, 32'h0);
      chk("alt_count", 32'(bus.sb_count), 32'd1);
      tick();
    end
    chk("alt_no_ovf", 32'(bus.sb_overflow), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 32'h100 + 32'(4 * k), 32'h0);
      chk("alt_ram", bus.readdata, 32'h5A000000 + 32'(k));
    end
    chk("alt_empty", 32'(bus.sb_empty), 32'd1);
    tick();

    // Fill to full, store while full without load, then the dropped illegal store.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'h200 + 32'(4 * k), 32'hC0 + 32'(k));
      tick();
    end
    drive(1'b0, 1'b1, 32'h204, 32'h0);
    chk("full_count", 32'(bus.sb_count), 32'd4);
    chk("full_fwd", bus.readdata, 32'hC1);
    chk("full_no_ovf", 32'(bus.sb_overflow), 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h210, 32'hC4);
    tick();
    drive(1'b0, 1'b1, 32'h210, 32'h0);
    chk("full_swap_count", 32'(bus.sb_count), 32'd4);
    chk("full_swap_fwd", bus.readdata, 32'hC4);
    chk("full_swap_no_ovf", 32'(bus.sb_overflow), 32'd0);
    tick();
    drive(1'b1, 1'b1, 32'h10, 32'h00000BAD);
    chk("drop_cycle_read", bus.readdata, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    chk("drop_not_fwd", bus.readdata, 32'hDEADBEEF);
    chk("drop_count", 32'(bus.sb_count), 32'd4);
    chk("ovf_set", 32'(bus.sb_overflow), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    chk("ovf_sticky", 32'(bus.sb_overflow), 32'd1);
    chk("full_drained_empty", 32'(bus.sb_empty), 32'd1);
    chk("drop_not_in_ram", bus.readdata, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 32'h200 + 32'(4 * k), 32'h0);
      chk("full_ram", bus.readdata, 32'hC0 + 32'(k));
    end
    tick();

    // Reset with three pending stores and a concurrent store: all lost.
    drive(1'b1, 1'b1, 32'h10, 32'hF0);
    tick();
    drive(1'b1, 1'b1, 32'h20, 32'hF1);
    tick();
    drive(1'b1, 1'b1, 32'h40, 32'hF2);
    tick();
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    chk("pend_fwd", bus.readdata, 32'hF1);
    chk("pend_count", 32'(bus.sb_count), 32'd3);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h10, 32'hEE);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    chk("rst_count", 32'(bus.sb_count), 32'd0);
    chk("rst_empty", 32'(bus.sb_empty), 32'd1);
    chk("rst_ovf_clear", 32'(bus.sb_overflow), 32'd0);
    chk("rst_ram_10", bus.readdata, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    chk("rst_ram_20", bus.readdata, 32'h11111111);
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    chk("rst_ram_40", bus.readdata, 32'h0000000B);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
